openram_scan_bridge: RTL and testbench

Host-side serial bridge for the OpenRAM test chip. It shifts a 56-bit SRAM command packet in serially and presents it in parallel on `gpio_packet` to the test chip's GPIO packet input. After a fixed latency it captures the chip's 32-bit `sram_data` result and, for read commands, shifts that result back out serially. All pins are driven from `clk_in`; there is no second clock domain.

---
 rtl/openram_tc_pkg.sv | 41 ++++
 rtl/openram_scan_bridge.sv | 147 ++++++++++++++
 tb/tb_openram_scan_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/openram_tc_pkg.sv
// Shared definitions for the OpenRAM test chip: packet layout, NOP constant
// and the scan bridge state encoding.
package openram_tc_pkg;

   localparam int PKT_W  = 56;
   localparam int DATA_W = 32;

   localparam int SEL_BIT   = 55;
   localparam int CSB0_BIT  = 54;
   localparam int WEB0_BIT  = 53;
   localparam int WMASK0_HI = 52;
   localparam int WMASK0_LO = 49;
   localparam int ADDR0_HI  = 48;
   localparam int ADDR0_LO  = 41;
   localparam int DIN0_HI   = 40;
   localparam int DIN0_LO   = 9;
   localparam int CSB1_BIT  = 8;
   localparam int ADDR1_HI  = 7;
   localparam int ADDR1_LO  = 0;

   localparam logic [PKT_W-1:0] NOP_PKT = 56'h40_0000_0000_0100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_IN,
      ST_LAUNCH,
      ST_WAIT,
      ST_CAPTURE,
      ST_SHIFT_OUT
   } bridge_state_e;

   // Deselect both ports while keeping every other field of the packet.
   function automatic logic [PKT_W-1:0] to_nop(input logic [PKT_W-1:0] pkt);
      logic [PKT_W-1:0] n;
      n           = pkt;
      n[CSB0_BIT] = 1'b1;
      n[CSB1_BIT] = 1'b1;
      return n;
   endfunction

endpackage

// File: rtl/openram_scan_bridge.sv
// Serial-to-parallel command bridge for the OpenRAM test chip: shifts a packet
// in, launches it on the GPIO pins, captures the result and shifts reads out.
module openram_scan_bridge #(
   parameter int PKT_W        = openram_tc_pkg::PKT_W,
   parameter int DATA_W       = openram_tc_pkg::DATA_W,
   parameter int READ_LATENCY = 4
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              scan_in,
   input  logic              scan_valid,
   input  logic [DATA_W-1:0] sram_data,
   output logic [PKT_W-1:0]  gpio_packet,
   output logic              scan_out,
   output logic              scan_out_valid,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);
   import openram_tc_pkg::*;

   bridge_state_e     state_q, state_d;
   logic [PKT_W-1:0]  in_sr_q, in_sr_d;
   logic [PKT_W-1:0]  gpio_q, gpio_d;
   logic [DATA_W-1:0] out_sr_q, out_sr_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              frame_err_q, frame_err_d;
   logic              read_req;

   assign read_req = (!gpio_q[CSB0_BIT] && gpio_q[WEB0_BIT]) || !gpio_q[CSB1_BIT];

   always_comb begin
      state_d     = state_q;
      in_sr_d     = in_sr_q;
      gpio_d      = gpio_q;
      out_sr_d    = out_sr_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      frame_err_d = frame_err_q;

      case (state_q)
         ST_IDLE: begin
            if (scan_valid) begin
               in_sr_d   = {in_sr_q[PKT_W-2:0], scan_in};
               bit_cnt_d = 6'd1;
               state_d   = ST_SHIFT_IN;
            end
         end
         ST_SHIFT_IN: begin
            if (scan_valid) begin
               in_sr_d = {in_sr_q[PKT_W-2:0], scan_in};
               if (bit_cnt_q == 6'(PKT_W - 1)) begin
                  bit_cnt_d = 6'd0;
                  state_d   = ST_LAUNCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end
            end
         end
         ST_LAUNCH: begin
            gpio_d     = in_sr_q;
            wait_cnt_d = 4'd0;
            state_d    = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'(READ_LATENCY - 2)) begin
               wait_cnt_d = 4'd0;
               state_d    = ST_CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_CAPTURE: begin
            // Only reads load the output register, so scan_out stays quiet on writes.
            if (read_req) begin
               out_sr_d    = sram_data;
               out_valid_d = 1'b1;
               bit_cnt_d   = 6'd0;
               state_d     = ST_SHIFT_OUT;
            end else begin
               done_d  = 1'b1;
               gpio_d  = to_nop(gpio_q);
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT_OUT: begin
            out_sr_d = {out_sr_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q == 6'(DATA_W - 1)) begin
               out_valid_d = 1'b0;
               bit_cnt_d   = 6'd0;
               done_d      = 1'b1;
               gpio_d      = to_nop(gpio_q);
               state_d     = ST_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + 6'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Serial data is only meaningful while assembling a packet.
      if (scan_valid && (state_q != ST_IDLE) && (state_q != ST_SHIFT_IN))
         frame_err_d = 1'b1;

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_sr_q     <= '0;
         gpio_q      <= NOP_PKT;
         out_sr_q    <= '0;
         bit_cnt_q   <= 6'd0;
         wait_cnt_q  <= 4'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_sr_q     <= in_sr_d;
         gpio_q      <= gpio_d;
         out_sr_q    <= out_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign gpio_packet    = gpio_q;
   assign scan_out       = out_sr_q[DATA_W-1];
   assign scan_out_valid = out_valid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_openram_scan_bridge.sv
// Bench for openram_scan_bridge with a cycle-level test chip model and a
// transaction-level memory reference.
module tb_openram_scan_bridge;

   localparam int LAT = 4;
   localparam logic [55:0] RST_PKT = 56'h40_0000_0000_0100;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        scan_in = 1'b0;
   logic        scan_valid = 1'b0;
   logic [31:0] sram_data = '0;
   logic [55:0] gpio_packet;
   logic        scan_out, scan_out_valid, busy, done, frame_err;

   int errors = 0;
   int checks = 0;
   logic [55:0] idle_gpio = RST_PKT;
   logic        exp_ferr = 1'b0;
   logic [31:0] ref_mem [0:1][0:255] = '{default: '0};
   logic [31:0] chip_mem [0:1][0:255] = '{default: '0};

   always #5 clk_in = ~clk_in;

   openram_scan_bridge #(.PKT_W(56), .DATA_W(32), .READ_LATENCY(LAT)) dut (
      .clk_in(clk_in), .rst(rst), .scan_in(scan_in), .scan_valid(scan_valid),
      .sram_data(sram_data), .gpio_packet(gpio_packet), .scan_out(scan_out),
      .scan_out_valid(scan_out_valid), .busy(busy), .done(done), .frame_err(frame_err)
   );

   // Test chip: registered read port data, byte-masked writes on port 0.
   always @(posedge clk_in) begin
      if (!gpio_packet[8])
         sram_data <= chip_mem[gpio_packet[55]][gpio_packet[7:0]];
      else if (!gpio_packet[54] && gpio_packet[53])
         sram_data <= chip_mem[gpio_packet[55]][gpio_packet[48:41]];
      if (!gpio_packet[54] && !gpio_packet[53])
         for (int b = 0; b < 4; b++)
            if (gpio_packet[49+b])
               chip_mem[gpio_packet[55]][gpio_packet[48:41]][8*b +: 8] = gpio_packet[9+8*b +: 8];
   end

   function automatic logic [55:0] mk(input logic sel, input logic csb0, input logic web0,
                                      input logic [3:0] wm, input logic [7:0] a0,
                                      input logic [31:0] din, input logic csb1, input logic [7:0] a1);
      return {sel, csb0, web0, wm, a0, din, csb1, a1};
   endfunction

   function automatic logic [55:0] nop(input logic [55:0] p);
      return p | RST_PKT;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends on a falling edge; abort_at >= 0 resets after that output bit.
   task automatic run_txn(input logic [55:0] pkt, input bit gapped, input bit err_pulse,
                          input int abort_at);
      logic        rd;
      logic [31:0] exp_d;
      logic [31:0] merged;
      rd    = (!pkt[54] && pkt[53]) || !pkt[8];
      exp_d = ref_mem[pkt[55]][!pkt[8] ? pkt[7:0] : pkt[48:41]];
      for (int i = 55; i >= 0; i--) begin
         scan_valid = 1'b1;
         scan_in    = pkt[i];
         @(negedge clk_in);
         if (gapped && i > 0) begin
            scan_valid = 1'b0;
            check("gap_gpio_hold", gpio_packet, idle_gpio);
            check("gap_busy", busy, 1);
            @(negedge clk_in);
         end
      end
      scan_valid = 1'b0;
      check("pre_launch_gpio", gpio_packet, idle_gpio);
      @(negedge clk_in);
      check("launch_gpio", gpio_packet, pkt);
      check("launch_busy", busy, 1);
      for (int k = 1; k <= LAT; k++) begin
         scan_valid = err_pulse && (k == 1);
         @(negedge clk_in);
         scan_valid = 1'b0;
         if (k < LAT) begin
            check("wait_gpio", gpio_packet, pkt);
            check("wait_done_valid", {done, scan_out_valid}, 0);
         end
      end
      if (err_pulse) exp_ferr = 1'b1;
      if (rd) begin
         for (int j = 0; j < 32; j++) begin
            check("so_valid", scan_out_valid, 1);
            check("so_bit", scan_out, exp_d[31-j]);
            if (j == abort_at) begin
               rst = 1'b1;
               @(negedge clk_in);
               rst = 1'b0;
               idle_gpio = RST_PKT;
               exp_ferr  = 1'b0;
               check("abort_valid", scan_out_valid, 0);
               check("abort_done", done, 0);
               check("abort_gpio", gpio_packet, RST_PKT);
               check("abort_busy", busy, 0);
               check("abort_ferr", frame_err, 0);
               return;
            end
            @(negedge clk_in);
         end
      end
      check("done_pulse", done, 1);
      check("done_valid", scan_out_valid, 0);
      check("done_nop", gpio_packet, nop(pkt));
      check("done_busy", busy, 0);
      check("frame_err", frame_err, exp_ferr);
      idle_gpio = nop(pkt);
      if (!pkt[54] && !pkt[53]) begin
         merged = ref_mem[pkt[55]][pkt[48:41]];
         for (int b = 0; b < 4; b++)
            if (pkt[49+b]) merged[8*b +: 8] = pkt[9+8*b +: 8];
         ref_mem[pkt[55]][pkt[48:41]] = merged;
      end
   endtask

   initial begin
      logic        sel;
      logic [7:0]  addr;
      logic [31:0] d;
      logic [3:0]  m;
      rst = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      check("rst_gpio", gpio_packet, RST_PKT);
      check("rst_flags", {scan_out, scan_out_valid, busy, done, frame_err}, 0);
      rst = 1'b0;
      @(negedge clk_in);

      // SRAM0 write then read back through port 1.
      run_txn(mk(1'b0, 1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00), 0, 0, -1);
      @(negedge clk_in);
      check("after_done", done, 0);
      run_txn(mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10), 0, 0, -1);

      // Gapped write to SRAM1, then read with a stray bit during WAIT.
      d = $urandom;
      run_txn(mk(1'b1, 1'b0, 1'b0, 4'hF, 8'h5A, d, 1'b1, 8'hFF), 1, 0, -1);
      run_txn(mk(1'b1, 1'b0, 1'b1, 4'h0, 8'h5A, 32'h0, 1'b1, 8'h00), 0, 1, -1);
      @(negedge clk_in);
      check("ferr_sticky", frame_err, 1);

      // Abort during shift-out, then a clean transaction.
      run_txn(mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10), 0, 0, 10);
      run_txn(mk(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10), 0, 0, -1);

      // Random back-to-back write/read pairs.
      for (int t = 0; t < 6; t++) begin
         sel  = 1'($urandom_range(0, 1));
         addr = 8'($urandom_range(0, 255));
         d    = $urandom;
         m    = 4'($urandom_range(1, 15));
         run_txn(mk(sel, 1'b0, 1'b0, m, addr, d, 1'b1, 8'($urandom_range(0, 255))), t[0], 0, -1);
         if ($urandom_range(0, 1) == 1)
            run_txn(mk(sel, 1'b1, 1'($urandom_range(0, 1)), 4'h0, 8'($urandom_range(0, 255)),
                       $urandom, 1'b0, addr), 0, 0, -1);
         else
            run_txn(mk(sel, 1'b0, 1'b1, 4'h0, addr, $urandom, 1'b1, 8'($urandom_range(0, 255))),
                    0, 0, -1);
      end

      @(negedge clk_in);
      check("final_idle", {busy, done, scan_out_valid}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
